// File: rtl/ika9958_pkg.sv
// Shared types and constants for the ika9958 CPU-port register-write front end.
package ika9958_pkg;

  typedef enum logic [1:0] {
    PORT0 = 2'd0,
    PORT1 = 2'd1,
    PORT2 = 2'd2,
    PORT3 = 2'd3
  } cpu_port_e;

  typedef enum logic {
    IDLE       = 1'b0,
    HAVE_FIRST = 1'b1
  } p1_state_e;

  localparam logic [5:0]  R17_IDX    = 6'd17;
  localparam int unsigned P1_REGFLAG = 7;
  localparam int unsigned P1_WRFLAG  = 6;

endpackage

// File: rtl/ika9958_cpuif_regwr.sv
// Decodes port #1 two-byte sequences and port #3 indirect writes into
// registered single-cycle register-write and VRAM-address-setup strobes.
module ika9958_cpuif_regwr
  import ika9958_pkg::*;
#(
  parameter int unsigned REG_AW   = 6,
  parameter int unsigned R17_ADDR = 32'(R17_IDX)
) (
  input  logic              i_EMUCLK,
  input  logic              i_RST,
  input  logic              i_CS,
  input  logic              i_WR,
  input  logic              i_RD,
  input  logic [1:0]        i_MODE,
  input  logic [7:0]        i_DIN,
  output logic              o_REG_WE,
  output logic [REG_AW-1:0] o_REG_ADDR,
  output logic [7:0]        o_REG_DATA,
  output logic [7:0]        o_R17,
  output logic              o_VADDR_SET,
  output logic [13:0]       o_VADDR,
  output logic              o_VADDR_WRITE
);

  localparam logic [REG_AW-1:0] R17_A = REG_AW'(R17_ADDR);

  p1_state_e         state_q, state_d;
  logic [7:0]        latch_q, latch_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              vset_q, vset_d;
  logic [13:0]       vaddr_q, vaddr_d;
  logic              vwr_q, vwr_d;
  logic [7:0]        r17_q, r17_d;

  cpu_port_e         port;
  logic              valid;
  logic              p1_wr, p1_rd, p3_wr;
  logic [REG_AW-1:0] ptr;

  assign port  = cpu_port_e'(i_MODE);
  assign valid = i_CS & (i_WR ^ i_RD);
  assign p1_wr = valid & i_WR & (port == PORT1);
  assign p1_rd = valid & i_RD & (port == PORT1);
  assign p3_wr = valid & i_WR & (port == PORT3);
  assign ptr   = r17_q[REG_AW-1:0];

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    vset_d  = 1'b0;
    vaddr_d = vaddr_q;
    vwr_d   = vwr_q;
    r17_d   = r17_q;

    if (p1_rd) begin
      // A status read resets the byte toggle; the latched first byte survives.
      state_d = IDLE;
    end else if (p1_wr) begin
      unique case (state_q)
        IDLE: begin
          latch_d = i_DIN;
          state_d = HAVE_FIRST;
        end
        HAVE_FIRST: begin
          state_d = IDLE;
          if (i_DIN[P1_REGFLAG]) begin
            we_d   = 1'b1;
            addr_d = i_DIN[REG_AW-1:0];
            data_d = latch_q;
            if (i_DIN[REG_AW-1:0] == R17_A) r17_d = latch_q;
          end else begin
            vset_d  = 1'b1;
            vaddr_d = {i_DIN[5:0], latch_q};
            vwr_d   = i_DIN[P1_WRFLAG];
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (p3_wr) begin
      // Indirect writes may not target the pointer itself, but still advance it.
      if (ptr != R17_A) begin
        we_d   = 1'b1;
        addr_d = ptr;
        data_d = i_DIN;
      end
      if (!r17_q[7]) r17_d = {r17_q[7:REG_AW], ptr + REG_AW'(1)};
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      latch_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      vset_q  <= 1'b0;
      vaddr_q <= '0;
      vwr_q   <= 1'b0;
      r17_q   <= '0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      vset_q  <= vset_d;
      vaddr_q <= vaddr_d;
      vwr_q   <= vwr_d;
      r17_q   <= r17_d;
    end
  end

  assign o_REG_WE      = we_q;
  assign o_REG_ADDR    = addr_q;
  assign o_REG_DATA    = data_q;
  assign o_R17         = r17_q;
  assign o_VADDR_SET   = vset_q;
  assign o_VADDR       = vaddr_q;
  assign o_VADDR_WRITE = vwr_q;

endmodule

// File: tb/tb_ika9958_cpuif_regwr.sv
// Table-driven directed vectors plus randomized traffic checked against a behavioural model.
module tb_ika9958_cpuif_regwr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  din = 8'h00;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_data;
  logic [7:0]  r17;
  logic        vset;
  logic [13:0] vaddr;
  logic        vwr;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit          m_have;
  int          m_first;
  bit          m_we, m_vset, m_vwr;
  int          m_addr, m_data, m_vaddr, m_r17;

  typedef struct {
    logic       cs, wr, rd;
    logic [1:0] mode;
    logic [7:0] din;
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
    logic       vset;
    logic [13:0] vaddr;
    logic       vwr;
    logic [7:0] r17;
  } vec_t;

  vec_t tbl[$];

  ika9958_cpuif_regwr #(.REG_AW(6), .R17_ADDR(17)) dut (
    .i_EMUCLK     (clk),
    .i_RST        (rst),
    .i_CS         (cs),
    .i_WR         (wr),
    .i_RD         (rd),
    .i_MODE       (mode),
    .i_DIN        (din),
    .o_REG_WE     (reg_we),
    .o_REG_ADDR   (reg_addr),
    .o_REG_DATA   (reg_data),
    .o_R17        (r17),
    .o_VADDR_SET  (vset),
    .o_VADDR      (vaddr),
    .o_VADDR_WRITE(vwr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit c, input bit w, input bit d,
                       input int md, input int v);
    bit ok;
    int p;
    if (r) begin
      m_have = 0; m_first = 0; m_we = 0; m_vset = 0; m_vwr = 0;
      m_addr = 0; m_data = 0; m_vaddr = 0; m_r17 = 0;
      return;
    end
    m_we = 0;
    m_vset = 0;
    ok = c && (w != d);
    if (ok && md == 1 && d) begin
      m_have = 0;
    end else if (ok && md == 1 && w) begin
      if (!m_have) begin
        m_first = v;
        m_have  = 1;
      end else begin
        m_have = 0;
        if (v >= 128) begin
          m_we = 1; m_addr = v % 64; m_data = m_first;
          if (m_addr == 17) m_r17 = m_first;
        end else begin
          m_vset = 1; m_vaddr = (v % 64) * 256 + m_first; m_vwr = (v / 64) % 2;
        end
      end
    end else if (ok && md == 3 && w) begin
      p = m_r17 % 64;
      if (p != 17) begin
        m_we = 1; m_addr = p; m_data = v;
      end
      if (m_r17 < 128) m_r17 = (m_r17 / 64) * 64 + (p + 1) % 64;
    end
  endtask

  task automatic step(input bit r, input bit c, input bit w, input bit d,
                      input logic [1:0] md, input logic [7:0] v);
    rst = r; cs = c; wr = w; rd = d; mode = md; din = v;
    @(posedge clk);
    #1;
    model(r, c, w, d, int'(md), int'(v));
    chk("m_we",    32'(reg_we), 32'(m_we));
    chk("m_addr",  32'(reg_addr), 32'(m_addr));
    chk("m_data",  32'(reg_data), 32'(m_data));
    chk("m_vset",  32'(vset), 32'(m_vset));
    chk("m_vaddr", 32'(vaddr), 32'(m_vaddr));
    chk("m_vwr",   32'(vwr), 32'(m_vwr));
    chk("m_r17",   32'(r17), 32'(m_r17));
  endtask

  task automatic add_raw(input logic c, input logic w, input logic d, input logic [1:0] md,
                         input logic [7:0] v, input logic we, input logic [5:0] a,
                         input logic [7:0] dt, input logic vs, input logic [13:0] va,
                         input logic vw, input logic [7:0] p);
    vec_t t;
    t.cs = c; t.wr = w; t.rd = d; t.mode = md; t.din = v;
    t.we = we; t.addr = a; t.data = dt; t.vset = vs; t.vaddr = va; t.vwr = vw; t.r17 = p;
    tbl.push_back(t);
  endtask

  task automatic add_w(input logic [1:0] md, input logic [7:0] v, input logic we,
                       input logic [5:0] a, input logic [7:0] dt, input logic vs,
                       input logic [13:0] va, input logic vw, input logic [7:0] p);
    add_raw(1'b1, 1'b1, 1'b0, md, v, we, a, dt, vs, va, vw, p);
  endtask

  initial begin
    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    chk("rst_we", 32'(reg_we), 0);
    chk("rst_vset", 32'(vset), 0);
    chk("rst_r17", 32'(r17), 0);

    add_w  (2'd1, 8'h3C, 0, 0, 8'h00, 0, 14'h0, 0, 8'h00);
    add_w  (2'd1, 8'h87, 1, 7, 8'h3C, 0, 14'h0, 0, 8'h00);
    add_raw(0, 0, 0, 2'd1, 8'h00, 0, 0, 8'h00, 0, 14'h0, 0, 8'h00);
    add_w  (2'd1, 8'h34, 0, 0, 8'h00, 0, 14'h0, 0, 8'h00);
    add_w  (2'd1, 8'h52, 0, 0, 8'h00, 1, 14'h1234, 1, 8'h00);
    add_raw(0, 0, 0, 2'd1, 8'h00, 0, 0, 8'h00, 0, 14'h0, 0, 8'h00);
    add_w  (2'd1, 8'hAA, 0, 0, 8'h00, 0, 14'h0, 0, 8'h00);
    add_raw(1, 0, 1, 2'd1, 8'h00, 0, 0, 8'h00, 0, 14'h0, 0, 8'h00);
    add_w  (2'd1, 8'h81, 0, 0, 8'h00, 0, 14'h0, 0, 8'h00);
    add_w  (2'd1, 8'h82, 1, 2, 8'h81, 0, 14'h0, 0, 8'h00);
    add_w  (2'd1, 8'h3E, 0, 0, 8'h00, 0, 14'h0, 0, 8'h00);
    add_w  (2'd1, 8'h91, 1, 17, 8'h3E, 0, 14'h0, 0, 8'h3E);
    add_w  (2'd3, 8'h11, 1, 62, 8'h11, 0, 14'h0, 0, 8'h3F);
    add_w  (2'd3, 8'h22, 1, 63, 8'h22, 0, 14'h0, 0, 8'h00);
    add_w  (2'd3, 8'h33, 1, 0, 8'h33, 0, 14'h0, 0, 8'h01);
    add_w  (2'd1, 8'h85, 0, 0, 8'h00, 0, 14'h0, 0, 8'h01);
    add_w  (2'd1, 8'h91, 1, 17, 8'h85, 0, 14'h0, 0, 8'h85);
    add_w  (2'd3, 8'h01, 1, 5, 8'h01, 0, 14'h0, 0, 8'h85);
    add_w  (2'd3, 8'h01, 1, 5, 8'h01, 0, 14'h0, 0, 8'h85);
    add_w  (2'd1, 8'h11, 0, 0, 8'h00, 0, 14'h0, 0, 8'h85);
    add_w  (2'd1, 8'h91, 1, 17, 8'h11, 0, 14'h0, 0, 8'h11);
    add_w  (2'd3, 8'hFF, 0, 0, 8'h00, 0, 14'h0, 0, 8'h12);
    add_w  (2'd1, 8'h40, 0, 0, 8'h00, 0, 14'h0, 0, 8'h12);
    add_raw(1, 1, 1, 2'd1, 8'h55, 0, 0, 8'h00, 0, 14'h0, 0, 8'h12);
    add_raw(1, 0, 0, 2'd1, 8'h56, 0, 0, 8'h00, 0, 14'h0, 0, 8'h12);
    add_w  (2'd0, 8'h99, 0, 0, 8'h00, 0, 14'h0, 0, 8'h12);
    add_w  (2'd2, 8'h98, 0, 0, 8'h00, 0, 14'h0, 0, 8'h12);
    add_w  (2'd1, 8'h83, 1, 3, 8'h40, 0, 14'h0, 0, 8'h12);
    add_w  (2'd1, 8'h5A, 0, 0, 8'h00, 0, 14'h0, 0, 8'h12);
    add_w  (2'd3, 8'h77, 1, 18, 8'h77, 0, 14'h0, 0, 8'h13);
    add_w  (2'd1, 8'h84, 1, 4, 8'h5A, 0, 14'h0, 0, 8'h13);
    add_w  (2'd1, 8'hC7, 0, 0, 8'h00, 0, 14'h0, 0, 8'h13);
    add_w  (2'd1, 8'hD1, 1, 17, 8'hC7, 0, 14'h0, 0, 8'hC7);
    add_w  (2'd3, 8'hAB, 1, 7, 8'hAB, 0, 14'h0, 0, 8'hC7);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].cs, tbl[i].wr, tbl[i].rd, tbl[i].mode, tbl[i].din);
      chk("tbl_we", 32'(reg_we), 32'(tbl[i].we));
      chk("tbl_vset", 32'(vset), 32'(tbl[i].vset));
      chk("tbl_r17", 32'(r17), 32'(tbl[i].r17));
      if (tbl[i].we) begin
        chk("tbl_addr", 32'(reg_addr), 32'(tbl[i].addr));
        chk("tbl_data", 32'(reg_data), 32'(tbl[i].data));
      end
      if (tbl[i].vset) begin
        chk("tbl_vaddr", 32'(vaddr), 32'(tbl[i].vaddr));
        chk("tbl_vwr", 32'(vwr), 32'(tbl[i].vwr));
      end
    end

    // reset in HAVE_FIRST with a completing second byte on the same edge
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h66);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 8'h88);
    chk("mid_rst_we", 32'(reg_we), 0);
    chk("mid_rst_addr", 32'(reg_addr), 0);
    chk("mid_rst_data", 32'(reg_data), 0);
    chk("mid_rst_r17", 32'(r17), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h89);
    chk("post_rst_first", 32'(reg_we), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h85);
    chk("post_rst_we", 32'(reg_we), 1);
    chk("post_rst_addr", 32'(reg_addr), 5);
    chk("post_rst_data", 32'(reg_data), 32'h89);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom),
           2'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ika9958_cpuif_regwr.md
Name: ika9958_cpuif_regwr

Overview:
CPU-port register-write front end for the V9958 core. It sits directly upstream of the register file and decodes the Z80-side port #1 two-byte sequence and port #3 indirect writes, including R#17 auto-increment, into single-cycle register write commands. Port #1 sequences that are VRAM address setups are forwarded as a separate strobe for the VRAM access stage.

Parameters:
REG_AW, 6, register address width (64-entry register space)
R17_ADDR, 17, index of the indirect-pointer register

Ports:
i_EMUCLK  in  1  master clock, all logic rising-edge
i_RST  in  1  synchronous active-high reset
i_CS  in  1  one-cycle, already-synchronised CPU access strobe
i_WR  in  1  with i_CS: write access
i_RD  in  1  with i_CS: read access
i_MODE  in  2  port select: 0=port #0, 1=port #1, 2=port #2, 3=port #3
i_DIN  in  8  CPU write data
o_REG_WE  out  1  one-cycle register write strobe
o_REG_ADDR  out  6  register index for o_REG_WE
o_REG_DATA  out  8  register data for o_REG_WE
o_R17  out  8  current indirect pointer (R#17 shadow)
o_VADDR_SET  out  1  one-cycle VRAM address setup strobe
o_VADDR  out  14  VRAM address {second[5:0], first[7:0]}
o_VADDR_WRITE  out  1  second-byte bit 6 (1 = write-mode setup)

Behaviour:
- Decided interface: one clock, i_EMUCLK; reset i_RST is synchronous and active-high.
- Reset: all outputs 0; o_R17=8'h00; first-byte latch=0; FSM=IDLE.
- An access is valid only when i_CS=1 and exactly one of i_WR/i_RD is 1. i_CS with both or neither set is ignored. Accesses to ports #0 and #2 are ignored.
- Port #1 FSM, states IDLE and HAVE_FIRST:
  - IDLE + port #1 write: latch i_DIN, go to HAVE_FIRST.
  - HAVE_FIRST + port #1 write, i_DIN[7]=1: register write to addr i_DIN[5:0], data = latched byte; return to IDLE. i_DIN[6] is ignored.
  - HAVE_FIRST + port #1 write, i_DIN[7]=0: o_VADDR_SET pulse with o_VADDR={i_DIN[5:0], latch} and o_VADDR_WRITE=i_DIN[6]; return to IDLE.
  - Port #1 read in any state: force IDLE, because a status read resets the byte toggle. The latch keeps its value.
- Port #3 write: register write to addr o_R17[5:0], data i_DIN.
  - If the target is R17_ADDR, the write is suppressed and the pointer is not changed; the auto-increment rule still applies.
  - After the write, if o_R17[7]=0, o_R17[5:0] increments modulo 64 (63 wraps to 0). o_R17[7:6] are unchanged.
  - Port #3 writes do not affect the port #1 FSM.
- Any register write whose address equals R17_ADDR, coming from port #1, also loads o_R17 with the data in the same cycle as the strobe.
- Latency: o_REG_WE, o_REG_ADDR and o_REG_DATA are registered and valid the cycle after the qualifying access. The same applies to o_VADDR_SET.
- o_REG_ADDR/o_REG_DATA hold their last values when o_REG_WE=0. o_VADDR/o_VADDR_WRITE hold the same way when o_VADDR_SET=0.
- Strobes last one cycle. Back-to-back accesses produce back-to-back strobes with no throttling.
- Reset asserted mid-sequence (HAVE_FIRST): return to IDLE. Any strobe scheduled for the next cycle is cancelled; outputs are 0 that cycle.

Decomposition:
- Shared package ika9958_pkg holds:
  - typedef cpu_port_e (PORT0..PORT3)
  - typedef p1_state_e (IDLE, HAVE_FIRST)
  - constant R17_IDX=6'd17
  - constants for the bit positions P1_REGFLAG=7 and P1_WRFLAG=6
- No sub-module. The indirect-pointer counter is a small always_ff inside this block.

Test Plan:
- Port #1 write 8'h3C, then 8'h87 -> next cycle o_REG_WE=1, o_REG_ADDR=7, o_REG_DATA=8'h3C; one pulse only.
- Port #1 write 8'h34, then 8'h52 -> o_VADDR_SET=1, o_VADDR=14'h1234, o_VADDR_WRITE=1; o_REG_WE stays 0.
- Port #1 write 8'hAA, port #1 read, port #1 write 8'h81 -> no register write. The 8'h81 becomes the new first byte, and a following 8'h82 writes R2=8'h81.
- Set R17=8'h3E via port #1 (8'h3E, 8'h91); port #3 writes 8'h11, 8'h22, 8'h33 -> writes R62=8'h11, R63=8'h22, R0=8'h33; o_R17 ends at 8'h01.
- Set R17=8'h85; port #3 writes 8'h01 twice -> both write R5; o_R17 stays 8'h85.
- Set R17=8'h11; port #3 write 8'hFF -> no strobe; o_R17 becomes 8'h12. Assert i_RST while in HAVE_FIRST -> all outputs 0 and FSM IDLE the next cycle.
